matvec_mem_engine: RTL and testbench

//  Parametrised matrix-vector engine: Avalon-MM read master fetches vector B (COLS elems), then matrix A
//  (ROWS x COLS, row-major), MACs on the fly (A never stored), produces C = A*B and sum(C).

---
 rtl/matvec_mem_engine_pkg.sv | 29 ++
 rtl/matvec_mem_engine_if.sv | 29 ++
 rtl/matvec_mem_engine_mac_unit.sv | 45 ++++
 rtl/matvec_mem_engine.sv | 185 ++++++++++++++++++
 tb/tb_matvec_mem_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matvec_mem_engine_pkg.sv
// Shared FSM state type, default sizes and accumulator width helpers
// for the streaming matrix-vector engine.
package matvec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_B_REQ,
    S_B_WAIT,
    S_A_REQ,
    S_A_WAIT,
    S_FINISH
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_COLS       = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_AVM_WIDTH  = 32;

  // A dot product of COLS full-scale products cannot overflow this width.
  function automatic int acc_width(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols);
  endfunction

  function automatic int sum_width(input int data_width, input int cols, input int rows);
    return acc_width(data_width, cols) + $clog2(rows);
  endfunction

endpackage

// File: rtl/matvec_mem_engine_if.sv
// Avalon-MM read-only bus between the engine (master) and memory (slave).
interface matvec_mem_engine_if #(
  parameter int ADDR_WIDTH = matvec_pkg::DEF_ADDR_WIDTH,
  parameter int AVM_WIDTH  = matvec_pkg::DEF_AVM_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest;
  logic [AVM_WIDTH-1:0]  avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/matvec_mem_engine_mac_unit.sv
// Multiply-accumulate stage: combinational product plus running sum,
// with a registered accumulator that can be cleared or advanced.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  add_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  total_o
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

  logic [ACC_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;

  if (SIGNED != 0) begin : g_signed
    logic signed [PROD_WIDTH-1:0] p_s;
    assign p_s  = PROD_WIDTH'($signed(a_i)) * PROD_WIDTH'($signed(b_i));
    assign prod = {{EXT_WIDTH{p_s[PROD_WIDTH-1]}}, p_s};
  end else begin : g_unsigned
    logic [PROD_WIDTH-1:0] p_u;
    assign p_u  = PROD_WIDTH'(a_i) * PROD_WIDTH'(b_i);
    assign prod = {{EXT_WIDTH{1'b0}}, p_u};
  end

  assign acc_d   = acc_q + prod;
  assign total_o = acc_d;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matvec_mem_engine.sv
// Matrix-vector engine: reads B, then streams A row-major over Avalon-MM and
// accumulates C = A*B on the fly (A is never buffered), plus sum(C).
module matvec_mem_engine
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int SIGNED     = 0,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AVM_WIDTH  = DEF_AVM_WIDTH,
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COLS),
  localparam int SUM_WIDTH = sum_width(DATA_WIDTH, COLS, ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  matvec_mem_engine_if.master   avm,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  c_vector [ROWS],
  output logic [SUM_WIDTH-1:0]  sum
);

  localparam int STRIDE = AVM_WIDTH / 8;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IDX_W  = $clog2(ROWS * COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q;
  logic [DATA_WIDTH-1:0] b_q [COLS];
  logic [ACC_WIDTH-1:0]  c_q [ROWS];
  logic [SUM_WIDTH-1:0]  sum_q;

  logic                  launch, b_beat, a_beat, row_done, mac_clear, mac_add;
  logic [DATA_WIDTH-1:0] rd_elem;
  logic [ACC_WIDTH-1:0]  row_total;
  logic [SUM_WIDTH-1:0]  row_total_ext;

  assign rd_elem   = avm.avm_readdata[DATA_WIDTH-1:0];
  assign launch    = (state_q == S_IDLE) && start;
  assign b_beat    = (state_q == S_B_WAIT) && avm.avm_readdatavalid;
  assign a_beat    = (state_q == S_A_WAIT) && avm.avm_readdatavalid;
  assign row_done  = a_beat && (col_q == COL_LAST);
  assign mac_clear = launch || row_done;
  assign mac_add   = a_beat && !row_done;

  if (AVM_WIDTH > DATA_WIDTH) begin : g_unused_rdata
    logic unused_rdata;
    assign unused_rdata = ^avm.avm_readdata[AVM_WIDTH-1:DATA_WIDTH];
  end

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (mac_clear),
    .add_i   (mac_add),
    .a_i     (rd_elem),
    .b_i     (b_q[col_q]),
    .total_o (row_total)
  );

  // Row results widen into the sum with the same signedness as the elements.
  assign row_total_ext = {{(SUM_WIDTH - ACC_WIDTH){(SIGNED != 0) && row_total[ACC_WIDTH-1]}},
                          row_total};

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    idx_d           = idx_q;
    avm.avm_read    = 1'b0;
    avm.avm_address = '0;
    busy            = 1'b1;
    done            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_B_REQ;
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
        end
      end
      S_B_REQ, S_A_REQ: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = ((state_q == S_A_REQ) ? a_base_q : b_base_q)
                          + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(STRIDE);
        if (!avm.avm_waitrequest) begin
          state_d = (state_q == S_A_REQ) ? S_A_WAIT : S_B_WAIT;
        end
      end
      S_B_WAIT: begin
        if (avm.avm_readdatavalid) begin
          if (col_q == COL_LAST) begin
            state_d = S_A_REQ;
            col_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_B_REQ;
            col_d   = col_q + 1'b1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_A_WAIT: begin
        if (avm.avm_readdatavalid) begin
          idx_d = idx_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_FINISH;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_A_REQ;
            end
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_A_REQ;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_base_q <= '0;
      b_base_q <= '0;
      sum_q    <= '0;
      for (int i = 0; i < ROWS; i++) c_q[i] <= '0;
      for (int i = 0; i < COLS; i++) b_q[i] <= '0;
    end else begin
      if (launch) begin
        a_base_q <= a_base;
        b_base_q <= b_base;
        sum_q    <= '0;
        for (int i = 0; i < ROWS; i++) c_q[i] <= '0;
      end
      if (b_beat) begin
        b_q[col_q] <= rd_elem;
      end
      if (row_done) begin
        c_q[row_q] <= row_total;
        sum_q      <= sum_q + row_total_ext;
      end
    end
  end

  assign c_vector = c_q;
  assign sum      = sum_q;

endmodule

// File: tb/tb_matvec_mem_engine.sv
// Directed bench: an unsigned and a signed 8x8 engine share one Avalon memory model.
`timescale 1ns/1ps
module tb_matvec_mem_engine;

  localparam int AW = 19;
  localparam int SW = 22;
  localparam logic [31:0] A_BASE = 32'h0000_0100;
  localparam logic [31:0] B_BASE = 32'h0000_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [31:0]   a_base, b_base;
  logic          busy0, done0, busy1, done1;
  logic [AW-1:0] c0 [8];
  logic [AW-1:0] c1 [8];
  logic [SW-1:0] sum0, sum1;

  int checks = 0;
  int errors = 0;

  matvec_mem_engine_if #(.ADDR_WIDTH(32), .AVM_WIDTH(32)) bus0 (), bus1 ();

  matvec_mem_engine #(.SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .a_base(a_base), .b_base(b_base),
    .avm(bus0), .busy(busy0), .done(done0), .c_vector(c0), .sum(sum0)
  );

  matvec_mem_engine #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .a_base(a_base), .b_base(b_base),
    .avm(bus1), .busy(busy1), .done(done1), .c_vector(c1), .sum(sum1)
  );

  // Memory model: word-addressed, programmable stall count and read latency.
  logic [31:0] mem [256];
  logic        wr;
  logic        rdv        = 1'b0;
  logic [31:0] rdata      = '0;
  logic [31:0] pend_data  = '0;
  int          stall_cfg  = 0;
  int          stall_cnt  = 0;
  int          lat_fix    = 1;
  bit          lat_rand   = 1'b0;
  int          pend       = 0;
  int          accepts    = 0;
  int          lat_v;

  assign wr = (stall_cnt < stall_cfg);
  assign bus0.avm_waitrequest   = wr;
  assign bus1.avm_waitrequest   = wr;
  assign bus0.avm_readdatavalid = rdv;
  assign bus1.avm_readdatavalid = rdv;
  assign bus0.avm_readdata      = rdata;
  assign bus1.avm_readdata      = rdata;

  always @(posedge clk) begin
    rdv <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        rdv   <= 1'b1;
        rdata <= pend_data;
      end
    end
    if (bus0.avm_read && wr) stall_cnt <= stall_cnt + 1;
    if (bus0.avm_read && !wr) begin
      stall_cnt <= 0;
      accepts   <= accepts + 1;
      lat_v = lat_rand ? int'($urandom_range(4, 1)) : lat_fix;
      if (lat_v == 1) begin
        rdv   <= 1'b1;
        rdata <= mem[bus0.avm_address[9:2]];
      end else begin
        pend      <= lat_v - 1;
        pend_data <= mem[bus0.avm_address[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Bus monitor: a stalled request must hold, and both engines must issue identical reads.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_read_held", 32'(bus0.avm_read), 32'd1);
      chk("stall_addr_held", bus0.avm_address, prev_addr);
    end
    if (rst_n === 1'b1 && bus0.avm_read === 1'b1) begin
      chk("signed_addr_match", bus1.avm_address, bus0.avm_address);
    end
    prev_stall = bus0.avm_read && wr;
    prev_addr  = bus0.avm_address;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int mode, input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int c = 0; c < 8; c++) mem[16 + c] = {24'hA5A5A5, (mode == 0) ? 8'(c + 1) : v};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        mem[64 + r * 8 + c] = {24'h5A5A5A, (mode == 0) ? ((r == c) ? 8'd1 : 8'd0) : v};
      end
    end
  endtask

  task automatic launch(input logic [31:0] ab, input logic [31:0] bb);
    a_base = ab;
    b_base = bb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Returns cycles from start to done and the busy cycles preceding done.
  task automatic wait_done(input int pulse_at, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (done0 !== 1'b1 && lat < 4000) begin
      start  = (pulse_at != 0) && (lat == pulse_at);
      a_base = start ? 32'h0000_0300 : A_BASE;
      if (busy0 === 1'b1) bcnt++;
      tick();
      lat++;
    end
    start  = 1'b0;
    a_base = A_BASE;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_read"}, 32'(bus0.avm_read), 32'd0);
    chk({tag, "_addr"}, bus0.avm_address, 32'd0);
    chk({tag, "_sum_u"}, 32'(sum0), 32'd0);
    chk({tag, "_sum_s"}, 32'(sum1), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_c_u[%0d]", tag, i), 32'(c0[i]), 32'd0);
  endtask

  task automatic check_res(input string tag, input int mode, input logic [31:0] u,
                           input logic [31:0] s, input logic [31:0] us, input logic [31:0] ss);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_c_u[%0d]", tag, i), 32'(c0[i]), (mode == 0) ? 32'(i + 1) : u);
      chk($sformatf("%s_c_s[%0d]", tag, i), 32'(c1[i]), (mode == 0) ? 32'(i + 1) : s);
    end
    chk({tag, "_sum_u"}, 32'(sum0), us);
    chk({tag, "_sum_s"}, 32'(sum1), ss);
    $display("%s: sum_u=%0d sum_s=%0d", tag, sum0, sum1);
  endtask

  initial begin
    int lat, bcnt, base, n;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_base = '0;
    b_base = '0;
    load(0, 8'h00);
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Identity matrix, B = 1..8, zero wait states.
    launch(A_BASE, B_BASE);
    wait_done(0, lat, bcnt);
    chk("t1_latency", 32'(lat), 32'd145);
    chk("t1_busy_cycles", 32'(bcnt), 32'd144);
    chk("t1_done_signed", 32'(done1), 32'd1);
    check_res("t1", 0, 0, 0, 36, 36);
    tick();
    chk("t1_done_pulse", 32'(done0), 32'd0);
    chk("t1_busy_drop", 32'(busy0), 32'd0);

    // All 0xFF: unsigned worst case, signed (-1)*(-1).
    load(1, 8'hFF);
    launch(A_BASE, B_BASE);
    wait_done(0, lat, bcnt);
    check_res("t2", 1, 520200, 8, 4161600, 64);
    tick();

    // All 0x80: most negative signed operand squared.
    load(1, 8'h80);
    launch(A_BASE, B_BASE);
    wait_done(0, lat, bcnt);
    check_res("t3", 1, 131072, 131072, 1048576, 1048576);
    tick();

    // Three waitrequest cycles on every read.
    load(0, 8'h00);
    stall_cfg = 3;
    launch(A_BASE, B_BASE);
    wait_done(0, lat, bcnt);
    stall_cfg = 0;
    chk("t4_stall_latency", 32'(lat), 32'd361);
    check_res("t4a", 0, 0, 0, 36, 36);
    tick();

    // Random read latency 1..4.
    lat_rand = 1'b1;
    launch(A_BASE, B_BASE);
    wait_done(0, lat, bcnt);
    lat_rand = 1'b0;
    check_res("t4b", 0, 0, 0, 36, 36);
    tick();

    // Start re-pulsed mid-run (with a different A base) and during FINISH.
    launch(A_BASE, B_BASE);
    wait_done(10, lat, bcnt);
    chk("t5_latency", 32'(lat), 32'd145);
    check_res("t5", 0, 0, 0, 36, 36);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_finish_start_busy", 32'(busy0), 32'd0);
    n = 0;
    repeat (4) begin
      tick();
      if (done0 === 1'b1) n++;
    end
    chk("t5_extra_dones", 32'(n), 32'd0);
    chk("t5_c_held", 32'(c0[7]), 32'd8);
    launch(A_BASE, B_BASE);
    chk("t5_clear_c0", 32'(c0[0]), 32'd0);
    chk("t5_clear_sum", 32'(sum0), 32'd0);
    chk("t5_busy_after_start", 32'(busy0), 32'd1);
    wait_done(0, lat, bcnt);
    check_res("t5b", 0, 0, 0, 36, 36);
    tick();

    // Reset during A row 3 with a read still in flight.
    lat_fix = 3;
    base    = accepts;
    launch(A_BASE, B_BASE);
    n = 0;
    while (accepts < base + 34 && n < 500) begin
      tick();
      n++;
    end
    chk("t6_reached_row3", 32'(c0[2]), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("t6_reset");
    repeat (4) tick();
    check_idle("t6_late_rdv");
    lat_fix = 1;
    launch(A_BASE, B_BASE);
    wait_done(0, lat, bcnt);
    chk("t6_latency", 32'(lat), 32'd145);
    check_res("t6", 0, 0, 0, 36, 36);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
